serial_host_link: RTL and testbench



---
 rtl/serial_link_pkg.sv | 19 +
 rtl/serial_link_shifter.sv | 42 ++++
 rtl/serial_host_link.sv | 148 ++++++++++++++
 tb/tb_serial_host_link.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared types for the host side of the bit-serial sample link.
package serial_link_pkg;

   localparam int DEFAULT_DATA_WIDTH = 24;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SHIFT,
      TX_GAP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_ARM,
      RX_WAIT,
      RX_SHIFT,
      RX_HOLD
   } rx_state_t;

endpackage

// File: rtl/serial_link_shifter.sv
// LSB-first shift register with a bit counter; used once for TX and once for RX.
module serial_link_shifter #(
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift_en,
   input  logic                  sin,
   output logic                  sout,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  done
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] data;
   logic [CW-1:0]         cnt;

   // NOTE: nonblocking assignments so data and cnt both update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
         cnt  <= '0;
      end else if (load) begin
         data <= load_data;
         cnt  <= '0;
      end else if (shift_en) begin
         data <= word;
         cnt  <= cnt + 1'b1;
      end
   end

   assign sout = data[0];
   // Parallel view of the register once the bit now on sin has been taken.
   assign word = {sin, data[DATA_WIDTH-1:1]};
   // High while the bit currently in flight is the final one of the word.
   assign done = (cnt == LAST);

endmodule

// File: rtl/serial_host_link.sv
// Host endpoint of the FIR bit-serial link: parallel-to-serial TX and
// serial-to-parallel RX, running independently under a shared enable.
module serial_host_link
   import serial_link_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_tx_word,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic                  o_sdout,
   output logic                  o_sdout_valid,
   input  logic                  i_sready,
   input  logic                  i_sdin,
   input  logic                  i_sdin_valid,
   output logic                  o_sready,
   output logic [DATA_WIDTH-1:0] o_rx_word,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ready
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   tx_state_t             tx_state, tx_next;
   logic                  tx_load, tx_shift, tx_done, tx_sout;
   logic [DATA_WIDTH-1:0] tx_word_unused;
   logic [GW-1:0]         gap_cnt;

   rx_state_t             rx_state, rx_next;
   logic                  rx_load, rx_shift, rx_done, rx_sout_unused;
   logic [DATA_WIDTH-1:0] rx_word;

   serial_link_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_tx_shifter (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (tx_load),
      .load_data (i_tx_word),
      .shift_en  (tx_shift),
      .sin       (1'b0),
      .sout      (tx_sout),
      .word      (tx_word_unused),
      .done      (tx_done)
   );

   serial_link_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_rx_shifter (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (rx_load),
      .load_data ('0),
      .shift_en  (rx_shift),
      .sin       (i_sdin),
      .sout      (rx_sout_unused),
      .word      (rx_word),
      .done      (rx_done)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state <= TX_IDLE;
         gap_cnt  <= '0;
      end else begin
         tx_state <= tx_next;
         if (i_en) begin
            if (tx_state == TX_GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
            else                                           gap_cnt <= '0;
         end
      end
   end

   // NOTE: defaults first; any path that skipped an assignment would infer a latch.
   always_comb begin
      tx_next  = tx_state;
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      if (i_en) begin
         case (tx_state)
            TX_IDLE: begin
               if (i_tx_valid) begin
                  tx_load = 1'b1;
                  tx_next = TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (i_sready) begin
                  tx_shift = 1'b1;
                  if (tx_done) tx_next = TX_GAP;
               end
            end
            TX_GAP: begin
               if (gap_cnt == GAP_LAST) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
         endcase
      end
   end

   assign o_tx_ready    = (tx_state == TX_IDLE) && !i_rst;
   assign o_sdout_valid = (tx_state == TX_SHIFT);
   assign o_sdout       = o_sdout_valid && tx_sout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state   <= RX_ARM;
         o_rx_word  <= '0;
         o_rx_valid <= 1'b0;
      end else begin
         rx_state   <= rx_next;
         o_rx_valid <= (rx_next == RX_HOLD);
         if (rx_shift && rx_done) o_rx_word <= rx_word;
      end
   end

   always_comb begin
      rx_next  = rx_state;
      rx_load  = 1'b0;
      rx_shift = 1'b0;
      if (i_en) begin
         case (rx_state)
            // A level left high from the previous word must fall before re-arming.
            RX_ARM: begin
               if (!i_sdin_valid) rx_next = RX_WAIT;
            end
            RX_WAIT: begin
               if (i_sdin_valid) begin
                  rx_load = 1'b1;
                  rx_next = RX_SHIFT;
               end
            end
            RX_SHIFT: begin
               rx_shift = 1'b1;
               if (rx_done) rx_next = RX_HOLD;
            end
            RX_HOLD: begin
               if (i_rx_ready) rx_next = RX_ARM;
            end
            default: rx_next = RX_ARM;
         endcase
      end
   end

   assign o_sready = (rx_state == RX_SHIFT);

endmodule

// File: tb/tb_serial_host_link.sv
// Self-checking bench for serial_host_link: directed vector table, corner
// sequences, and a randomized TX-to-RX loopback against a word-level model.
`timescale 1ns/1ps
module tb_serial_host_link;

   localparam int DW    = 24;
   localparam int NLOOP = 220;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic [DW-1:0] tx_word = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          sdout, sdout_valid;
   logic          f_ready = 1'b0;
   logic          sdin = 1'b0;
   logic          sdin_valid = 1'b0;
   logic          h_ready;
   logic [DW-1:0] rx_word;
   logic          rx_valid;
   logic          rx_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_host_link #(.DATA_WIDTH(DW), .GAP_CYCLES(1)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_tx_word     (tx_word),
      .i_tx_valid    (tx_valid),
      .o_tx_ready    (tx_ready),
      .o_sdout       (sdout),
      .o_sdout_valid (sdout_valid),
      .i_sready      (f_ready),
      .i_sdin        (sdin),
      .i_sdin_valid  (sdin_valid),
      .o_sready      (h_ready),
      .o_rx_word     (rx_word),
      .o_rx_valid    (rx_valid),
      .i_rx_ready    (rx_ready)
   );

   typedef struct {
      logic sready;
      logic exp_valid;
      logic exp_sdout;
      logic exp_ready;
   } vec_t;

   vec_t tx_tab [DW+2];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sends one TX word; toggle=1 alternates i_sready 1/0. Returns the bits taken.
   task automatic tx_send(input logic [DW-1:0] word, input bit toggle,
                          output logic [DW-1:0] got, output int nbits, output bit held_ok);
      logic prev_sready, prev_bit;
      bit   have_prev;
      got = '0; nbits = 0; held_ok = 1'b1; have_prev = 1'b0;
      prev_sready = 1'b0; prev_bit = 1'b0;
      for (int c = 0; c < 50 && !tx_ready; c++) step();
      tx_word = word; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!sdout_valid) break;
         f_ready = toggle ? (c % 2 == 0) : 1'b1;
         if (have_prev && !prev_sready && sdout !== prev_bit) held_ok = 1'b0;
         if (f_ready) begin
            if (nbits < DW) got[nbits] = sdout;
            nbits++;
         end
         have_prev = 1'b1; prev_sready = f_ready; prev_bit = sdout;
         step();
      end
      f_ready = 1'b0;
   endtask

   // Acts as the filter: raises valid and drives bits LSB-first while o_sready is high.
   task automatic rx_send(input logic [DW-1:0] word, output int n_sready);
      int idx;
      idx = 0; n_sready = 0;
      sdin_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (h_ready) begin
            sdin = (idx < DW) ? word[idx] : 1'b0;
            idx++;
            n_sready++;
         end else if (idx >= DW) begin
            break;
         end
         step();
      end
      sdin_valid = 1'b0;
      sdin = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] w, got;
      int            nb;
      bit            held, hold_ok;
      logic [DW-1:0] tx_exp[$], flt_q[$], rx_exp[$];
      logic [DW-1:0] tx_acc, expw;
      int            sent, recv, tx_bits, f_idx, quiet;
      bit            f_active, tx_took, post_last;

      // Reset state
      @(negedge clk);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_sdout_valid", sdout_valid, 0);
      check("rst_sdout", sdout, 0);
      check("rst_sready", h_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_word", rx_word, 0);
      rst = 1'b0;
      #1;
      check("post_rst_tx_ready", tx_ready, 1);
      step();

      // Table-driven TX word with i_sready held high
      w = 24'hA5C3F1;
      for (int k = 0; k < DW; k++) tx_tab[k] = '{1'b1, 1'b1, w[k], 1'b0};
      tx_tab[DW]   = '{1'b1, 1'b0, 1'b0, 1'b0};
      tx_tab[DW+1] = '{1'b1, 1'b0, 1'b0, 1'b1};
      tx_word = w; tx_valid = 1'b1; f_ready = 1'b1;
      step();
      tx_valid = 1'b0;
      for (int k = 0; k < DW + 2; k++) begin
         f_ready = tx_tab[k].sready;
         check($sformatf("tab_valid[%0d]", k), sdout_valid, tx_tab[k].exp_valid);
         check($sformatf("tab_sdout[%0d]", k), sdout, tx_tab[k].exp_sdout);
         check($sformatf("tab_ready[%0d]", k), tx_ready, tx_tab[k].exp_ready);
         step();
      end
      f_ready = 1'b0;

      // Same word with i_sready toggling
      tx_send(w, 1'b1, got, nb, held);
      check("toggle_nbits", nb, DW);
      check("toggle_word", got, w);
      check("toggle_held", held, 1);

      // RX word
      rx_send(24'h123456, nb);
      check("rx1_sready_cycles", nb, DW);
      check("rx1_sready_low", h_ready, 0);
      check("rx1_valid", rx_valid, 1);
      check("rx1_word", rx_word, 24'h123456);

      // Back-pressure: second word offered while the first is held
      sdin_valid = 1'b1;
      hold_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (h_ready !== 1'b0 || rx_valid !== 1'b1 || rx_word !== 24'h123456) hold_ok = 1'b0;
      end
      check("hold_backpressure", hold_ok, 1);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      check("hold_release_valid", rx_valid, 0);
      // The filter re-announces its pending word with a fresh valid edge.
      sdin_valid = 1'b0;
      step();
      rx_send(24'h89ABCD, nb);
      check("rx2_sready_cycles", nb, DW);
      check("rx2_word", rx_word, 24'h89ABCD);
      check("rx2_valid", rx_valid, 1);

      // Reset at TX bit 10 (RX result still held, so reset must clear it too)
      tx_word = 24'h3C0FF1; tx_valid = 1'b1; f_ready = 1'b1;
      step();
      tx_valid = 1'b0;
      for (int k = 0; k < 10; k++) step();
      rst = 1'b1;
      step();
      check("txrst_sdout_valid", sdout_valid, 0);
      check("txrst_sdout", sdout, 0);
      check("txrst_tx_ready", tx_ready, 0);
      check("txrst_rx_valid", rx_valid, 0);
      check("txrst_rx_word", rx_word, 0);
      rst = 1'b0; f_ready = 1'b0;
      #1;
      check("txrst_ready_after", tx_ready, 1);
      tx_send(24'h5A5A0F, 1'b0, got, nb, held);
      check("txrst_next_nbits", nb, DW);
      check("txrst_next_word", got, 24'h5A5A0F);

      // Reset at RX bit 5
      step();
      sdin_valid = 1'b1;
      nb = 0;
      for (int c = 0; c < 100 && nb < 5; c++) begin
         if (h_ready) begin
            sdin = 1'b1;
            nb++;
         end
         step();
      end
      check("rxrst_reached_bit5", h_ready, 1);
      rst = 1'b1;
      step();
      check("rxrst_sready", h_ready, 0);
      check("rxrst_rx_valid", rx_valid, 0);
      check("rxrst_rx_word", rx_word, 0);
      check("rxrst_sdout_valid", sdout_valid, 0);
      rst = 1'b0; sdin_valid = 1'b0; sdin = 1'b0;
      step();
      rx_send(24'hE1D2C3, nb);
      check("rxrst_next_cycles", nb, DW);
      check("rxrst_next_word", rx_word, 24'hE1D2C3);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;

      // Randomized loopback: TX bits are re-sent by a filter model into RX
      sent = 0; recv = 0; tx_bits = 0; f_idx = 0; quiet = 0;
      f_active = 1'b0; tx_took = 1'b0; post_last = 1'b0; tx_acc = '0;
      for (int cyc = 0; cyc < 60000 && recv < NLOOP; cyc++) begin
         if (tx_took) tx_valid = 1'b0;
         tx_took = 1'b0;
         if (post_last) begin
            check("loop_sready_len", h_ready, 0);
            check("loop_rx_valid_set", rx_valid, 1);
            post_last = 1'b0;
         end

         en       = ($urandom_range(7) != 0);
         f_ready  = ($urandom_range(3) != 0);
         rx_ready = ($urandom_range(2) == 0);
         if (!tx_valid && sent < NLOOP && $urandom_range(1) == 1) begin
            tx_word  = DW'($urandom);
            tx_valid = 1'b1;
         end
         if (!f_active && flt_q.size() > 0 && quiet >= 1) f_active = 1'b1;
         sdin_valid = f_active;
         sdin       = f_active ? flt_q[0][f_idx] : 1'b0;

         if (en) begin
            if (tx_valid && tx_ready) begin
               tx_exp.push_back(tx_word);
               sent++;
               tx_took = 1'b1;
            end
            if (sdout_valid && f_ready) begin
               tx_acc[tx_bits] = sdout;
               tx_bits++;
               if (tx_bits == DW) begin
                  tx_bits = 0;
                  if (tx_exp.size() == 0) begin
                     check("loop_tx_unexpected", 1, 0);
                  end else begin
                     expw = tx_exp.pop_front();
                     check("loop_tx_word", tx_acc, expw);
                     flt_q.push_back(expw);
                  end
               end
            end
            if (f_active && h_ready) begin
               f_idx++;
               if (f_idx == DW) begin
                  rx_exp.push_back(flt_q.pop_front());
                  f_idx = 0;
                  f_active = 1'b0;
                  post_last = 1'b1;
               end
            end
            if (rx_valid && rx_ready) begin
               if (rx_exp.size() == 0) begin
                  check("loop_rx_unexpected", 1, 0);
               end else begin
                  expw = rx_exp.pop_front();
                  check("loop_rx_word", rx_word, expw);
               end
               recv++;
            end
            quiet = (!rx_valid && !f_active && !post_last) ? quiet + 1 : 0;
         end
         step();
      end
      en = 1'b1; tx_valid = 1'b0; sdin_valid = 1'b0; rx_ready = 1'b0; f_ready = 1'b0;
      check("loop_words_received", recv, NLOOP);
      check("loop_queues_empty", tx_exp.size() + flt_q.size() + rx_exp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
